reduce_table_unit: RTL and testbench
====================================

# reduce_table_unit

Parametrised, pipelined reduction table for collective operations (ShortReduce/LargeReduce/AllReduce) in the router. It accepts reduction flits one per cycle over a valid/ready handshake, merges contributions from children into a table slot through a fixed-latency combiner, and emits one completed flit per finished slot over a second valid/ready handshake. It replaces the fixed 2-entry, add-only table with a configurable depth, a configurable combiner latency, six reduction functions and proper back-pressure on both sides.

## Interface
- `rank_z`, `rank_y`, `rank_x`, default 0: this node's coordinates (3 bits each).
- `lg_numprocs`, default 3: children-field width.
- `LgDepth`, default 2: table depth is 2^LgDepth slots.
- `OpLatency`, default 4, minimum 1: combiner pipeline stages.
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: reset, asynchronous and active-low.
- `in_flit` in 82+lg_numprocs: bits [81:0] are the standard flit; bits above 81 are the children count, which is the number of further contributions expected for this slot.
- `in_fn` in 3: reduction function, sampled with the flit.
- `in_valid` in 1 / `in_ready` out 1: input handshake.
- `out_flit` out 82: completed flit.
- `out_valid` out 1 / `out_ready` in 1: output handshake.
- `occupancy` out LgDepth+1: number of slots not free.

## Operation
- **Classification.** A flit is a reduction flit when valid bit 81 = 1 and op[35:34] = 2'b11.
  - Non-reduction flits are consumed: `in_ready` is high and the flit is dropped.
- **Slot index.**
  - If dst[80:72] equals {rank_z, rank_y, rank_x}: the index is tag[LgDepth-1:0].
  - Otherwise: the index is dst_z zero-extended or truncated to LgDepth bits.
- **Slot states.**
  - FREE: no contribution held.
  - ACTIVE: holds a partial result and a `remaining` count.
  - PENDING: a combine for this slot is in the pipeline.
  - DONE: queued for output.
- **Acceptance.** `in_ready` = 1 unless the target slot is PENDING or DONE.
  - It is computed from registered state only.
- **FREE slot.** Store the flit [81:0], `in_fn` and `remaining` = children.
  - If children = 0, the slot goes directly to DONE and is pushed to the completion queue.
- **ACTIVE slot.** Launch (slot payload, flit payload, stored fn) into the combiner; the slot goes to PENDING.
  - The incoming `in_fn` and header are ignored.
- **Combiner writeback, OpLatency cycles after launch.**
  - Write the result into the slot payload and decrement `remaining`.
  - If `remaining` reaches 0, the slot goes to DONE and is pushed to the queue; otherwise it returns to ACTIVE.
- **Reduction functions.** Results are 32-bit.
  - 000: sum modulo 2^32.
  - 001: signed max.
  - 010: signed min.
  - 011: AND.
  - 100: OR.
  - 101: XOR.
  - 110 and 111: treated as sum.
- **Completion queue.** FIFO of slot indices, depth 2^LgDepth, which is enough to never overflow.
  - Two pushes in one cycle (a writeback completion and a leaf acceptance) are both taken, writeback first.
- **Output flit,** built from the head slot of the queue:
  - payload = slot payload;
  - op becomes Gather (4'b1011) when {algtype, op} = {01, 1101}, otherwise it is unchanged;
  - algtype = 00;
  - bits [81:38] are copied from the slot with bit 81 forced to 1.
- **Output pop.** On `out_valid` && `out_ready`, pop the queue and set the slot to FREE.

## Timing
- **During and after reset:**
  - all slots FREE, queue empty, pipeline empty;
  - `out_valid` = 0, `out_flit` = 0, `occupancy` = 0, `in_ready` = 0.
- **First cycle after reset release:** `in_ready` = 1.
- **Leaf accepted at cycle t:** `out_valid` is high at t+1 when the queue was empty.
- **Combine accepted at t:** the slot is PENDING during t+1 .. t+OpLatency, and the result is visible at t+OpLatency+1.
  - If that combine completes the slot, `out_valid` is high at t+OpLatency+1 when the queue was empty.
- **Output.** `out_flit` and `out_valid` are stable while `out_ready` = 0; one pop per cycle.
- **Pop and new flit to the same slot in the same cycle:** the input stalls that cycle and is accepted the next.
- **Different slots:** a pop and a writeback in the same cycle are independent.
- **Reset mid-operation:** pipeline contents, queued results and partial sums are discarded with no output.

## Test plan
- **Leaf.** Local flit, tag 2, children 0, payload 7, fn 000 at t → `out_valid` at t+1 with payload 7 and valid bit 1; after a pop, `occupancy` = 0.
- **Sum with back-to-back stall.**
  - Flits with payloads 5, 3, 10 to slot 1; the first has children 2; all fn 000.
  - The second flit is accepted; the third sees `in_ready` = 0 for OpLatency cycles.
  - Required result: out payload 18.
- **Signed functions.**
  - fn 001 with payloads 0xFFFFFFFE then 0x00000003 → out 0x00000003.
  - fn 010 with the same payloads → out 0xFFFFFFFE.
  - fn 101 with 0xF0F0F0F0 then 0xFF00FF00 → out 0x0FF00FF0.
- **Back-pressure and rewrite.**
  - Two leaves (LargeReduce, algtype 01) to slots 0 and 3, with `out_ready` held at 0 for 10 cycles.
  - Both outputs are held stable, op = 1011, algtype = 00, emitted in arrival order.
  - A new flit to slot 0 stalls until slot 0 is popped.
- **Dual push.** A writeback completing slot 2 coincides with the acceptance of a leaf to slot 1 → both are queued, slot 2 emitted first; a non-reduction flit interleaved with them is consumed and produces no output.
- **Reset mid-combine.** Assert `rst` low while a combine is PENDING → `out_valid` and `occupancy` are 0 immediately; no output appears after release.

Source files
------------

// File: rtl/reduce_table_unit_if.sv
// Handshake bundle for reduce_table_unit: reduction flits in, completed flits out.
// The master side is the flit producer / result consumer; the slave side is the table.
interface reduce_table_unit_if #(
    parameter int lg_numprocs = 3,
    parameter int LgDepth     = 2
);
    logic [81+lg_numprocs:0] in_flit;
    logic [2:0]              in_fn;
    logic                    in_valid;
    logic                    in_ready;
    logic [81:0]             out_flit;
    logic                    out_valid;
    logic                    out_ready;
    logic [LgDepth:0]        occupancy;

    modport master (
        output in_flit, in_fn, in_valid, out_ready,
        input  in_ready, out_flit, out_valid, occupancy
    );

    modport slave (
        input  in_flit, in_fn, in_valid, out_ready,
        output in_ready, out_flit, out_valid, occupancy
    );
endinterface

// File: rtl/reduce_table_unit.sv
// Pipelined reduction table: merges child contributions per slot through a fixed-latency
// combiner and emits one completed flit per finished slot, in completion order.
module reduce_table_unit #(
    parameter logic [2:0] rank_z      = 3'd0,
    parameter logic [2:0] rank_y      = 3'd0,
    parameter logic [2:0] rank_x      = 3'd0,
    parameter int         lg_numprocs = 3,
    parameter int         LgDepth     = 2,
    parameter int         OpLatency   = 4
) (
    input logic                 clk,
    input logic                 rst,
    reduce_table_unit_if.slave  bus
);
    localparam int DEPTH   = 1 << LgDepth;
    localparam int CW      = LgDepth + 1;
    localparam int STAGES  = OpLatency - 1;
    localparam int TAG_LSB = 38;

    localparam logic [1:0] ST_FREE    = 2'd0;
    localparam logic [1:0] ST_ACTIVE  = 2'd1;
    localparam logic [1:0] ST_PENDING = 2'd2;
    localparam logic [1:0] ST_DONE    = 2'd3;

    logic                               run_q;
    logic                               is_red;
    logic [LgDepth-1:0]                 idx;
    logic [lg_numprocs-1:0]             children;
    logic [1:0]                         tgt_st;
    logic                               rdy, acc, fill_any, launch;
    logic [31:0]                        alu_a, alu_b, alu_y;
    logic [2:0]                         alu_fn;

    logic [DEPTH-1:0][1:0]              slot_st;
    logic [DEPTH-1:0][80:0]             slot_data;
    logic [DEPTH-1:0][2:0]              slot_fn;
    logic [DEPTH-1:0][lg_numprocs-1:0]  slot_rem;

    logic [STAGES:0]                    vld_pipe;
    logic [STAGES:0][LgDepth-1:0]       slot_pipe;
    logic [STAGES:0][31:0]              res_pipe;
    logic                               wb;
    logic [LgDepth-1:0]                 wb_slot;
    logic [31:0]                        wb_res;

    logic [DEPTH-1:0][LgDepth-1:0]      q;
    logic [LgDepth-1:0]                 wr_ptr, rd_ptr, head;
    logic [CW-1:0]                      cnt, occ;
    logic                               push_wb, push_leaf, pop, out_valid;
    logic [1:0]                         n_push;
    logic [80:0]                        hd;

    // Decode: local flits index by tag, remote flits by destination z.
    assign is_red   = bus.in_flit[81] && (bus.in_flit[35:34] == 2'b11);
    assign children = bus.in_flit[82 +: lg_numprocs];
    assign idx      = (bus.in_flit[80:72] == {rank_z, rank_y, rank_x}) ?
                      bus.in_flit[TAG_LSB +: LgDepth] : LgDepth'(bus.in_flit[80:78]);
    assign tgt_st   = slot_st[idx];

    // Ready looks only at registered slot state, never at same-cycle pops or writebacks.
    assign rdy          = run_q && (!is_red || tgt_st == ST_FREE || tgt_st == ST_ACTIVE);
    assign bus.in_ready = rdy;
    assign acc          = bus.in_valid && rdy && is_red;
    assign fill_any     = acc && (tgt_st == ST_FREE);
    assign launch       = acc && (tgt_st == ST_ACTIVE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) run_q <= 1'b0;
        else      run_q <= 1'b1;
    end

    assign alu_a  = slot_data[idx][31:0];
    assign alu_b  = bus.in_flit[31:0];
    assign alu_fn = slot_fn[idx];

    always_comb begin
        alu_y = alu_a + alu_b;
        case (alu_fn)
            3'b001:  alu_y = ($signed(alu_a) > $signed(alu_b)) ? alu_a : alu_b;
            3'b010:  alu_y = ($signed(alu_a) < $signed(alu_b)) ? alu_a : alu_b;
            3'b011:  alu_y = alu_a & alu_b;
            3'b100:  alu_y = alu_a | alu_b;
            3'b101:  alu_y = alu_a ^ alu_b;
            default: alu_y = alu_a + alu_b;
        endcase
    end

    // Result is computed at launch and simply carried for OpLatency cycles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_pipe  <= '0;
            slot_pipe <= '0;
            res_pipe  <= '0;
        end else begin
            vld_pipe[0]  <= launch;
            slot_pipe[0] <= idx;
            res_pipe[0]  <= alu_y;
            for (int k = 1; k <= STAGES; k++) begin
                vld_pipe[k]  <= vld_pipe[k-1];
                slot_pipe[k] <= slot_pipe[k-1];
                res_pipe[k]  <= res_pipe[k-1];
            end
        end
    end

    assign wb      = vld_pipe[STAGES];
    assign wb_slot = slot_pipe[STAGES];
    assign wb_res  = res_pipe[STAGES];

    assign head      = q[rd_ptr];
    assign out_valid = (cnt != '0);
    assign pop       = out_valid && bus.out_ready;

    for (genvar i = 0; i < DEPTH; i++) begin : g_slot
        reduce_table_slot #(.lg_numprocs(lg_numprocs)) u_slot (
            .clk       (clk),
            .rst       (rst),
            .fill      (fill_any && idx == LgDepth'(i)),
            .launch    (launch && idx == LgDepth'(i)),
            .wb        (wb && wb_slot == LgDepth'(i)),
            .pop       (pop && head == LgDepth'(i)),
            .fill_data (bus.in_flit[80:0]),
            .fill_fn   (bus.in_fn),
            .fill_rem  (children),
            .wb_res    (wb_res),
            .st        (slot_st[i]),
            .data      (slot_data[i]),
            .fn        (slot_fn[i]),
            .rem       (slot_rem[i])
        );
    end

    assign push_wb   = wb && (slot_rem[wb_slot] == lg_numprocs'(1));
    assign push_leaf = fill_any && (children == '0);
    assign n_push    = {1'b0, push_wb} + {1'b0, push_leaf};

    // Writeback completion is queued ahead of a same-cycle leaf.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q      <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push_wb)   q[wr_ptr] <= wb_slot;
            if (push_leaf) q[push_wb ? wr_ptr + LgDepth'(1) : wr_ptr] <= idx;
            wr_ptr <= wr_ptr + LgDepth'(n_push);
            if (pop) rd_ptr <= rd_ptr + LgDepth'(1);
            cnt <= cnt + CW'(n_push) - CW'(pop);
        end
    end

    always_comb begin
        occ = '0;
        for (int i = 0; i < DEPTH; i++)
            if (slot_st[i] != ST_FREE) occ = occ + CW'(1);
    end
    assign bus.occupancy = occ;

    assign hd = slot_data[head];
    always_comb begin
        bus.out_flit = '0;
        if (out_valid)
            bus.out_flit = {1'b1, hd[80:38], 2'b00,
                            (hd[37:32] == 6'b01_1101) ? 4'b1011 : hd[35:32], hd[31:0]};
    end
    assign bus.out_valid = out_valid;
endmodule

// One table slot: header/payload storage, stored function, remaining count and state.
module reduce_table_slot #(
    parameter int lg_numprocs = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   fill,
    input  logic                   launch,
    input  logic                   wb,
    input  logic                   pop,
    input  logic [80:0]            fill_data,
    input  logic [2:0]             fill_fn,
    input  logic [lg_numprocs-1:0] fill_rem,
    input  logic [31:0]            wb_res,
    output logic [1:0]             st,
    output logic [80:0]            data,
    output logic [2:0]             fn,
    output logic [lg_numprocs-1:0] rem
);
    localparam logic [1:0] ST_FREE    = 2'd0;
    localparam logic [1:0] ST_ACTIVE  = 2'd1;
    localparam logic [1:0] ST_PENDING = 2'd2;
    localparam logic [1:0] ST_DONE    = 2'd3;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st   <= ST_FREE;
            data <= '0;
            fn   <= '0;
            rem  <= '0;
        end else if (fill) begin
            data <= fill_data;
            fn   <= fill_fn;
            rem  <= fill_rem;
            st   <= (fill_rem == '0) ? ST_DONE : ST_ACTIVE;
        end else if (launch) begin
            st <= ST_PENDING;
        end else if (wb) begin
            data[31:0] <= wb_res;
            rem        <= rem - lg_numprocs'(1);
            st         <= (rem == lg_numprocs'(1)) ? ST_DONE : ST_ACTIVE;
        end else if (pop) begin
            st <= ST_FREE;
        end
    end
endmodule

// File: tb/tb_reduce_table_unit.sv
// Bench for reduce_table_unit: directed scenarios plus random traffic, all checked
// cycle by cycle against a transaction-level model of the table.
module tb_reduce_table_unit;
    localparam int OPL   = 4;
    localparam int LGD   = 2;
    localparam int LGN   = 3;
    localparam int DEPTH = 1 << LGD;
    localparam int FW    = 82 + LGN;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    reduce_table_unit_if #(.lg_numprocs(LGN), .LgDepth(LGD)) bus ();
    reduce_table_unit #(.lg_numprocs(LGN), .LgDepth(LGD), .OpLatency(OPL))
        dut (.clk(clk), .rst(rst), .bus(bus));

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit m_run = 1'b0;

    bit          m_busy   [DEPTH];
    bit          m_queued [DEPTH];
    int          m_wb_at  [DEPTH];
    int          m_rem    [DEPTH];
    logic [31:0] m_pay    [DEPTH];
    logic [31:0] m_opnd   [DEPTH];
    logic [2:0]  m_fn     [DEPTH];
    logic [80:32] m_hdr   [DEPTH];
    logic [81:0] exp_q[$];
    int          exp_slot[$];
    logic [81:0] pop_log[$];
    logic [81:0] last_out;
    int          n_pops = 0;

    task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit is_red(input logic [FW-1:0] f);
        return f[81] && (f[35:34] == 2'b11);
    endfunction

    function automatic int m_index(input logic [FW-1:0] f);
        if (f[80:72] == 9'd0) return int'(f[45:38]) % DEPTH;
        return int'(f[80:78]) % DEPTH;
    endfunction

    function automatic logic [31:0] m_red(input logic [2:0] fn, input logic [31:0] a, input logic [31:0] b);
        case (fn)
            3'd1:    return (int'(a) > int'(b)) ? a : b;
            3'd2:    return (int'(a) < int'(b)) ? a : b;
            3'd3:    return a & b;
            3'd4:    return a | b;
            3'd5:    return a ^ b;
            default: return a + b;
        endcase
    endfunction

    function automatic logic [FW-1:0] mk(input logic [8:0] dst, input logic [7:0] tag, input logic [1:0] alg,
                                         input logic [3:0] op, input int ch, input logic [31:0] pay,
                                         input logic [25:0] misc);
        return {LGN'(ch), 1'b1, dst, misc, tag, alg, op, pay};
    endfunction

    function automatic logic [FW-1:0] loc(input int slot, input int ch, input logic [31:0] pay);
        return mk(9'd0, 8'(slot), 2'b00, 4'b1101, ch, pay, 26'h0);
    endfunction

    function automatic bit m_ready(input logic [FW-1:0] f);
        int s;
        if (!m_run) return 1'b0;
        if (!is_red(f)) return 1'b1;
        s = m_index(f);
        return !(m_busy[s] && (m_queued[s] || m_wb_at[s] >= cyc));
    endfunction

    function automatic int m_occ();
        int n = 0;
        for (int s = 0; s < DEPTH; s++) n += int'(m_busy[s]);
        return n;
    endfunction

    task automatic m_complete(input int s);
        logic [3:0] op;
        op = (m_hdr[s][37:32] == 6'b011101) ? 4'b1011 : m_hdr[s][35:32];
        m_queued[s] = 1'b1;
        exp_q.push_back({1'b1, m_hdr[s][80:38], 2'b00, op, m_pay[s]});
        exp_slot.push_back(s);
    endtask

    task automatic m_accept(input logic [FW-1:0] f, input logic [2:0] fn);
        int s;
        s = m_index(f);
        if (!m_busy[s]) begin
            m_busy[s] = 1'b1;
            m_hdr[s]  = f[80:32];
            m_pay[s]  = f[31:0];
            m_fn[s]   = fn;
            m_rem[s]  = int'(f[82 +: LGN]);
            if (m_rem[s] == 0) m_complete(s);
        end else begin
            m_opnd[s]  = f[31:0];
            m_wb_at[s] = cyc + OPL;
        end
    endtask

    task automatic model_clear();
        for (int s = 0; s < DEPTH; s++) begin
            m_busy[s] = 0; m_queued[s] = 0; m_wb_at[s] = -1; m_rem[s] = 0;
        end
        exp_q.delete();
        exp_slot.delete();
    endtask

    // One cycle: drive at negedge, check against the model, then advance the model at posedge.
    task automatic step(input bit v, input logic [FW-1:0] f, input logic [2:0] fn, input bit ordy,
                        output bit acc);
        bit pop;
        int s;
        @(negedge clk);
        bus.in_valid = v; bus.in_flit = f; bus.in_fn = fn; bus.out_ready = ordy;
        #1;
        chk("in_ready", bus.in_ready, m_ready(f));
        chk("out_valid", bus.out_valid, exp_q.size() != 0);
        if (exp_q.size() != 0) chk("out_flit", bus.out_flit, exp_q[0]);
        chk("occupancy", bus.occupancy, m_occ());
        acc = v && bus.in_ready;
        pop = bus.out_valid && ordy;
        @(posedge clk);
        for (s = 0; s < DEPTH; s++)
            if (m_wb_at[s] == cyc) begin
                m_pay[s] = m_red(m_fn[s], m_pay[s], m_opnd[s]);
                m_rem[s]--;
                m_wb_at[s] = -1;
                if (m_rem[s] == 0) m_complete(s);
            end
        if (acc && is_red(f)) m_accept(f, fn);
        if (pop && exp_q.size() != 0) begin
            s = exp_slot.pop_front();
            last_out = exp_q.pop_front();
            pop_log.push_back(last_out);
            m_busy[s] = 0; m_queued[s] = 0;
            n_pops++;
        end
        cyc++;
    endtask

    task automatic send(input logic [FW-1:0] f, input logic [2:0] fn, input bit ordy, output int waited);
        bit acc = 0;
        waited = 0;
        for (int i = 0; i < 30 && !acc; i++) begin
            step(1'b1, f, fn, ordy, acc);
            if (!acc) waited++;
        end
        chk("send_timeout", acc, 1'b1);
    endtask

    task automatic drain_one();
        bit acc;
        int p0 = n_pops;
        for (int i = 0; i < 30 && n_pops == p0; i++) step(1'b0, '0, 3'd0, 1'b1, acc);
        chk("pop_timeout", n_pops != p0, 1'b1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        bus.in_valid = 0; bus.out_ready = 0; bus.in_flit = '0; bus.in_fn = '0;
        #1;
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_out_flit", bus.out_flit, 82'd0);
        chk("rst_occupancy", bus.occupancy, 0);
        chk("rst_in_ready", bus.in_ready, 1'b0);
        model_clear();
        m_run = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        m_run = 1'b1;
        cyc++;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int w, accs, p0;
        bit acc;
        logic [2:0]  sfn [3] = '{3'd1, 3'd2, 3'd5};
        logic [31:0] sa  [3] = '{32'hFFFFFFFE, 32'hFFFFFFFE, 32'hF0F0F0F0};
        logic [31:0] sb  [3] = '{32'h00000003, 32'h00000003, 32'hFF00FF00};
        logic [31:0] sr  [3] = '{32'h00000003, 32'hFFFFFFFE, 32'h0FF00FF0};
        logic [FW-1:0] f, nr;

        bus.in_valid = 0; bus.out_ready = 0; bus.in_flit = '0; bus.in_fn = '0;
        do_reset();

        // Leaf completes immediately.
        send(loc(2, 0, 32'd7), 3'd0, 1'b0, w);
        drain_one();
        chk("leaf_payload", last_out[31:0], 32'd7);
        chk("leaf_valid_bit", last_out[81], 1'b1);
        @(negedge clk); #1;
        chk("leaf_occupancy", bus.occupancy, 0);

        // Back-to-back sum; third contribution stalls for the combiner latency.
        send(loc(1, 2, 32'd5), 3'd0, 1'b0, w);
        send(loc(1, 0, 32'd3), 3'd0, 1'b0, w);
        chk("sum_second_wait", w, 0);
        send(loc(1, 0, 32'd10), 3'd0, 1'b0, w);
        chk("sum_stall", w, OPL);
        drain_one();
        chk("sum_result", last_out[31:0], 32'd18);

        // Signed max/min and XOR.
        for (int i = 0; i < 3; i++) begin
            send(loc(3, 1, sa[i]), sfn[i], 1'b0, w);
            send(loc(3, 0, sb[i]), 3'd0, 1'b0, w);
            drain_one();
            chk($sformatf("fn%0d_result", sfn[i]), last_out[31:0], sr[i]);
        end

        // Back-pressure with LargeReduce rewrite; slot 0 must stay blocked until popped.
        pop_log.delete();
        send(mk(9'd0, 8'd0, 2'b01, 4'b1101, 0, 32'hA0, 26'h1234567), 3'd0, 1'b0, w);
        send(mk(9'd0, 8'd3, 2'b01, 4'b1101, 0, 32'hB3, 26'h2ABCDEF), 3'd0, 1'b0, w);
        f = mk(9'd0, 8'd0, 2'b00, 4'b1100, 0, 32'hC0, 26'h0);
        accs = 0;
        for (int i = 0; i < 10; i++) begin
            step(1'b1, f, 3'd0, 1'b0, acc);
            accs += int'(acc);
        end
        chk("bp_stalled_accepts", accs, 0);
        @(negedge clk); #1;
        chk("bp_op_rewrite", bus.out_flit[35:32], 4'b1011);
        chk("bp_algtype", bus.out_flit[37:36], 2'b00);
        send(f, 3'd0, 1'b1, w);
        chk("bp_same_slot_wait", w, 1);
        drain_one();
        chk("bp_pop_count", pop_log.size(), 3);
        if (pop_log.size() == 3) begin
            chk("bp_order0", pop_log[0][31:0], 32'hA0);
            chk("bp_order1", pop_log[1][31:0], 32'hB3);
            chk("bp_order2", pop_log[2][31:0], 32'hC0);
        end

        // Writeback to slot 2 coincides with a leaf to slot 1; non-reduction flits in between.
        pop_log.delete();
        nr = loc(0, 0, 32'hDEAD);
        nr[81] = 1'b0;
        send(loc(2, 1, 32'd100), 3'd0, 1'b0, w);
        send(loc(2, 0, 32'd23), 3'd0, 1'b0, w);
        accs = 0;
        for (int i = 0; i < OPL - 1; i++) begin
            step(1'b1, nr, 3'd0, 1'b0, acc);
            accs += int'(acc);
        end
        chk("nonred_consumed", accs, OPL - 1);
        step(1'b1, loc(1, 0, 32'h55), 3'd0, 1'b0, acc);
        chk("dual_leaf_accept", acc, 1'b1);
        drain_one();
        drain_one();
        chk("dual_pop_count", pop_log.size(), 2);
        if (pop_log.size() == 2) begin
            chk("dual_first", pop_log[0][31:0], 32'd123);
            chk("dual_second", pop_log[1][31:0], 32'h55);
        end
        @(negedge clk); #1;
        chk("dual_no_extra", bus.out_valid, 1'b0);

        // Reset while a combine is in flight.
        send(loc(1, 1, 32'd9), 3'd0, 1'b0, w);
        send(loc(1, 0, 32'd1), 3'd0, 1'b0, w);
        step(1'b0, '0, 3'd0, 1'b1, acc);
        do_reset();
        p0 = n_pops;
        for (int i = 0; i < OPL + 4; i++) step(1'b0, '0, 3'd0, 1'b1, acc);
        chk("post_reset_pops", n_pops - p0, 0);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            logic [8:0] dst;
            dst = ($urandom_range(0, 1) == 0) ? 9'd0 : 9'($urandom_range(1, 511));
            f = mk(dst, 8'($urandom), 2'($urandom), {2'b11, 2'($urandom)},
                   $urandom_range(0, 2), $urandom, 26'($urandom));
            if ($urandom_range(0, 9) < 2) begin
                if ($urandom_range(0, 1) == 0) f[81] = 1'b0;
                else f[35] = 1'b0;
            end
            step($urandom_range(0, 3) != 0, f, 3'($urandom), $urandom_range(0, 3) != 0, acc);
        end
        for (int i = 0; i < 60; i++) step(1'b0, '0, 3'd0, 1'b1, acc);
        @(negedge clk); #1;
        chk("drain_out_valid", bus.out_valid, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
